// File: rtl/display_frame_pkg.sv
// display_frame_pkg: frame geometry, header field offsets and packer FSM states shared with the image writer
package display_frame_pkg;
  localparam int BYTES_PER_LINE = 300;
  localparam int LINES = 100;
  localparam int HDR_BITS = 240;
  localparam int PAY_W = 8 * BYTES_PER_LINE;
  localparam int FRAME_W = HDR_BITS + PAY_W;
  localparam logic [31:0] SYNC_WORD = 32'hDA7A_F00D;
  localparam int OFS_SYNC = 0;
  localparam int OFS_IDX = 32;
  localparam int OFS_LEN = 48;
  localparam int OFS_CSUM = 64;
  localparam int OFS_PAD = 80;
  typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;
endpackage

// File: rtl/line_checksum_acc.sv
// line_checksum_acc: 16-bit running byte sum with synchronous clear (priority) and add enable
module line_checksum_acc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        add,
  input  logic [7:0]  din,
  output logic [15:0] sum
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sum <= '0;
    else if (clr) sum <= '0;
    else if (add) sum <= sum + {8'h00, din};
endmodule

// File: rtl/line_frame_packer.sv
// line_frame_packer: packs a line of pixel bytes plus header into one frame word with a write strobe.
// Define LINE_FRAME_CHECKSUM_EN to fill the header checksum field; otherwise it reads zero.
module line_frame_packer
  import display_frame_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               abort,
  output logic [0:FRAME_W-1] frame_data,
  output logic               write,
  output logic [15:0]        line_idx,
  output logic               image_done
);
  state_t state_q, state_d;
  logic [8:0] cnt;
  logic [0:PAY_W-1] line_buf, next_buf;
  logic [15:0] csum;
  logic take, last;
  assign s_ready = state_q == FILL;
  assign write = state_q == EMIT;
  assign image_done = write && line_idx == 16'(LINES - 1);
  assign take = s_valid && s_ready && !abort;
  assign last = cnt == 9'(BYTES_PER_LINE - 1);
  always_comb begin
    state_d = (state_q == FILL && !(take && last)) ? FILL : (state_q == FILL ? EMIT : FILL);
  end
  // the final byte is merged combinationally so the frame word is complete on the edge that raises write
  always_comb begin
    next_buf = line_buf;
    next_buf[{cnt, 3'b000} +: 8] = s_data;
  end
`ifdef LINE_FRAME_CHECKSUM_EN
  logic [15:0] acc;
  line_checksum_acc u_csum (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (abort || (take && last)),
    .add  (take),
    .din  (s_data),
    .sum  (acc)
  );
  assign csum = acc + {8'h00, s_data};
`else
  assign csum = '0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt <= '0;
      line_idx <= '0;
      line_buf <= '0;
      frame_data <= '0;
    end else begin
      state_q <= state_d;
      if (abort) cnt <= '0;
      else if (take) cnt <= last ? '0 : cnt + 9'd1;
      if (take) line_buf <= next_buf;
      if (take && last) begin
        frame_data[OFS_SYNC +: 32] <= SYNC_WORD;
        frame_data[OFS_IDX +: 16] <= line_idx;
        frame_data[OFS_LEN +: 16] <= 16'(BYTES_PER_LINE);
        frame_data[OFS_CSUM +: 16] <= csum;
        frame_data[OFS_PAD +: HDR_BITS - OFS_PAD] <= '0;
        frame_data[HDR_BITS +: PAY_W] <= next_buf;
      end
      if (abort) line_idx <= '0;
      else if (write) line_idx <= line_idx == 16'(LINES - 1) ? '0 : line_idx + 16'd1;
    end
endmodule

// File: tb/tb_line_frame_packer.sv
// tb_line_frame_packer: table-driven line streams checked against a scoreboard of expected frame words
module tb_line_frame_packer;
  import display_frame_pkg::*;
  logic clk = 0, rst_n = 0, s_valid = 0, abort = 0;
  logic [7:0] s_data = 0;
  logic s_ready, write, image_done;
  logic [0:FRAME_W-1] frame_data;
  logic [15:0] line_idx;

  line_frame_packer dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .abort(abort), .frame_data(frame_data), .write(write), .line_idx(line_idx),
    .image_done(image_done)
  );

  always #5 clk = ~clk;

`ifdef LINE_FRAME_CHECKSUM_EN
  localparam bit CS_EN = 1;
`else
  localparam bit CS_EN = 0;
`endif

  typedef struct {
    logic [15:0] idx;
    logic [15:0] csum;
    logic done;
    logic [0:PAY_W-1] pay;
    bit lat;
  } exp_t;

  typedef struct {
    string name;
    int lines;
    int pat;
    int gap;
    bit lat;
    int end_idx;
  } vec_t;

  exp_t sb[$];
  int checks = 0, failures = 0;
  int cyc = 0, m_idx = 0, t0 = 0;
  bit fresh = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [0:HDR_BITS-1] hdr;
    int bad;
    if (image_done) chk("image_done_needs_write", write, 1);
    if (write) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: write=1 with no line pending, line_idx=%0d", line_idx);
      end else begin
        e = sb.pop_front();
        hdr = frame_data[0:HDR_BITS-1];
        chk("hdr_sync", hdr[0:31], SYNC_WORD);
        chk("hdr_idx", hdr[32:47], e.idx);
        chk("hdr_len", hdr[48:63], BYTES_PER_LINE);
        chk("hdr_csum", hdr[64:79], e.csum);
        chk("hdr_pad", hdr[80:HDR_BITS-1], 0);
        chk("line_idx_out", line_idx, e.idx);
        chk("image_done", image_done, e.done);
        bad = -1;
        for (int k = 0; k < BYTES_PER_LINE; k++)
          if (bad < 0 && frame_data[HDR_BITS + 8*k +: 8] !== e.pay[8*k +: 8]) bad = k;
        checks++;
        if (bad >= 0) begin
          failures++;
          $display("FAIL payload: byte %0d got %02h expected %02h", bad,
                   frame_data[HDR_BITS + 8*bad +: 8], e.pay[8*bad +: 8]);
        end
        if (e.lat) chk("write_latency", cyc + 1 - t0, BYTES_PER_LINE);
      end
    end
  end

  task automatic idle_cycle();
    s_valid = 0;
    s_data = 8'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    bit rdy;
    int w = 0;
    s_data = d;
    s_valid = 1;
    do begin
      @(negedge clk);
      rdy = s_ready;
      if (!rdy && !fresh) chk("s_ready_low_only_in_emit", write, 1);
      @(posedge clk);
      #1;
      w++;
    end while (!rdy && w < 8);
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL s_ready_timeout: s_ready=0 for %0d cycles, required 1", w);
    end
    fresh = 0;
    s_valid = 0;
  endtask

  task automatic send_line(input int pat, input int gap, input bit lat);
    exp_t e;
    logic [15:0] s;
    logic [7:0] b;
    s = 0;
    for (int k = 0; k < BYTES_PER_LINE; k++) begin
      b = pat == 0 ? 8'(k) : pat == 1 ? 8'hFF : 8'($urandom);
      e.pay[8*k +: 8] = b;
      s += 16'(b);
    end
    e.idx = 16'(m_idx);
    e.done = m_idx == LINES - 1;
    e.csum = CS_EN ? s : 16'h0000;
    e.lat = lat;
    sb.push_back(e);
    m_idx = (m_idx + 1) % LINES;
    for (int k = 0; k < BYTES_PER_LINE; k++) begin
      if (gap > 0 && $urandom_range(99) < gap) idle_cycle();
      send_byte(e.pay[8*k +: 8]);
      if (k == 0) t0 = cyc;
    end
  endtask

  task automatic send_partial(input int n);
    for (int k = 0; k < n; k++) send_byte(8'($urandom));
  endtask

  task automatic do_abort();
    s_valid = 1;
    s_data = 8'($urandom);
    abort = 1;
    @(posedge clk);
    #1;
    abort = 0;
    s_valid = 0;
    m_idx = 0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 2000) begin
      @(posedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d writes outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_write"}, write, 0);
    chk({tag, "_image_done"}, image_done, 0);
    chk({tag, "_line_idx"}, line_idx, 0);
    checks++;
    if (frame_data !== '0) begin
      failures++;
      $display("FAIL %s_frame_data: got nonzero header %0h expected 0", tag, frame_data[0:79]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[4];
    tv[0] = '{"single_ramp", 1, 0, 0, 1, 1};
    tv[1] = '{"image_wrap", 101, 2, 0, 1, 2};
    tv[2] = '{"gaps", 3, 2, 30, 0, 5};
    tv[3] = '{"all_ff", 1, 1, 0, 1, 6};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst_n = 1;
    fresh = 1;
    for (int i = 0; i < 4; i++) begin
      for (int l = 0; l < tv[i].lines; l++) send_line(tv[i].pat, tv[i].gap, tv[i].lat);
      drain();
      @(negedge clk);
      chk({tv[i].name, "_end_idx"}, line_idx, tv[i].end_idx);
      @(posedge clk);
      #1;
    end
    // abort part-way through line 5: no write for it, fresh line restarts at index 0
    do_abort();
    for (int l = 0; l < 5; l++) send_line(2, 0, 0);
    drain();
    send_partial(150);
    do_abort();
    @(negedge clk);
    chk("abort_clears_idx", line_idx, 0);
    @(posedge clk);
    #1;
    send_line(0, 0, 1);
    drain();
    @(negedge clk);
    chk("post_abort_end_idx", line_idx, 1);
    @(posedge clk);
    #1;
    // reset mid-line 3: outputs clear immediately, first write afterwards is index 0
    for (int l = 0; l < 2; l++) send_line(2, 0, 0);
    drain();
    send_partial(200);
    #2;
    rst_n = 0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
    fresh = 1;
    m_idx = 0;
    send_line(0, 0, 1);
    drain();
    @(negedge clk);
    chk("post_reset_end_idx", line_idx, 1);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
